// File: rtl/cache_types.sv
// Shared types and sizes for the 4-way write-back cache controller.
package cache_types;

    localparam int unsigned N_SET  = 4;
    localparam int unsigned N_WAY  = 4;
    localparam int unsigned TAG_W  = 23;
    localparam int unsigned LINE_W = 256;
    localparam int unsigned WORD_W = 32;
    localparam int unsigned OFF_W  = 5;

    typedef enum logic [2:0] {
        IDLE,
        COMPARE,
        WRITEBACK,
        ALLOCATE,
        LOOKUP
    } state_t;

    typedef struct packed {
        logic [TAG_W-1:0] tag;
        logic [N_SET-1:0] index;
        logic [2:0]       word;
        logic [1:0]       offset;
    } addr_t;

    // Merge the enabled bytes of wdata into one word of a cache line.
    function automatic logic [LINE_W-1:0] merge_line(
        input logic [LINE_W-1:0] line,
        input logic [2:0]        word,
        input logic [3:0]        mask,
        input logic [WORD_W-1:0] wdata
    );
        logic [LINE_W-1:0] merged;
        merged = line;
        for (int b = 0; b < 4; b++) begin
            if (mask[b]) begin
                merged[{word, 2'(b), 3'b000} +: 8] = wdata[8*b +: 8];
            end
        end
        return merged;
    endfunction

endpackage

// File: rtl/plru_tree4.sv
// Tree pseudo-LRU for 4 ways: victim from state, and state after touching a way.
module plru_tree4 (
    input  logic [2:0] plru,
    input  logic [1:0] way,
    output logic [1:0] victim,
    output logic [2:0] plru_next
);

    always_comb begin
        victim    = plru[0] ? {1'b1, plru[2]} : {1'b0, plru[1]};
        plru_next = plru;
        plru_next[0] = ~way[1];
        if (!way[1]) begin
            plru_next[1] = ~way[0];
        end else begin
            plru_next[2] = ~way[0];
        end
    end

endmodule

// File: rtl/cache_ctrl.sv
// 4-way set-associative write-back/write-allocate cache controller driving
// external per-way tag/valid/dirty/data arrays and a shared PLRU array.
module cache_ctrl
    import cache_types::*;
(
    input  logic                    clk,
    input  logic                    rst_n,

    output logic                    ufp_ready,
    input  logic [31:0]             ufp_addr,
    input  logic [3:0]              ufp_rmask,
    input  logic [3:0]              ufp_wmask,
    input  logic [31:0]             ufp_wdata,
    output logic [31:0]             ufp_rdata,
    output logic                    ufp_resp,

    output logic [31:0]             dfp_addr,
    output logic                    dfp_read,
    output logic                    dfp_write,
    output logic [LINE_W-1:0]       dfp_wdata,
    input  logic [LINE_W-1:0]       dfp_rdata,
    input  logic                    dfp_resp,

    output logic                    arr_csb,
    output logic [N_SET-1:0]        arr_addr,
    output logic [N_WAY-1:0]        tag_web,
    output logic [N_WAY-1:0]        valid_web,
    output logic [N_WAY-1:0]        dirty_web,
    output logic [N_WAY-1:0]        data_web,
    output logic [TAG_W-1:0]        tag_din,
    output logic                    valid_din,
    output logic                    dirty_din,
    output logic [LINE_W-1:0]       data_din,
    input  logic [N_WAY*TAG_W-1:0]  tag_dout,
    input  logic [N_WAY-1:0]        valid_dout,
    input  logic [N_WAY-1:0]        dirty_dout,
    input  logic [N_WAY*LINE_W-1:0] data_dout,
    output logic                    plru_web,
    output logic [2:0]              plru_din,
    input  logic [2:0]              plru_dout
);

    state_t state, state_d;

    addr_t             in_addr;
    addr_t             req;
    logic [3:0]        req_wmask;
    logic [31:0]       req_wdata;
    logic [1:0]        victim_way;
    logic [TAG_W-1:0]  victim_tag;
    logic [LINE_W-1:0] victim_line;

    logic              capture;
    logic              latch_victim;

    logic [TAG_W-1:0]  way_tag  [N_WAY];
    logic [LINE_W-1:0] way_line [N_WAY];
    logic [N_WAY-1:0]  hit;
    logic              any_hit;
    logic [1:0]        hit_way;
    logic [LINE_W-1:0] hit_line;
    logic [1:0]        plru_victim;
    logic [2:0]        plru_next;
    logic [1:0]        miss_way;
    logic              miss_dirty;
    logic              unused_bits;

    assign in_addr     = addr_t'(ufp_addr);
    assign unused_bits = ^req.offset;

    // Split array outputs per way and detect a hit on the captured request.
    always_comb begin
        hit     = '0;
        hit_way = 2'd0;
        for (int unsigned w = 0; w < N_WAY; w++) begin
            way_tag[w]  = tag_dout[w*TAG_W +: TAG_W];
            way_line[w] = data_dout[w*LINE_W +: LINE_W];
            hit[w]      = valid_dout[w] && (way_tag[w] == req.tag);
            if (hit[w]) begin
                hit_way = 2'(w);
            end
        end
        any_hit  = |hit;
        hit_line = way_line[hit_way];
    end

    plru_tree4 u_plru (
        .plru      (plru_dout),
        .way       (hit_way),
        .victim    (plru_victim),
        .plru_next (plru_next)
    );

    // Fill an empty way first; only evict through PLRU when the set is full.
    always_comb begin
        logic found;
        found    = 1'b0;
        miss_way = plru_victim;
        for (int unsigned w = 0; w < N_WAY; w++) begin
            if (!found && !valid_dout[w]) begin
                miss_way = 2'(w);
                found    = 1'b1;
            end
        end
        miss_dirty = valid_dout[miss_way] && dirty_dout[miss_way];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    // Next state plus all array and bus controls.
    always_comb begin
        state_d      = state;
        capture      = 1'b0;
        latch_victim = 1'b0;
        ufp_ready    = 1'b0;
        ufp_resp     = 1'b0;
        ufp_rdata    = '0;
        dfp_addr     = '0;
        dfp_read     = 1'b0;
        dfp_write    = 1'b0;
        dfp_wdata    = '0;
        arr_csb      = 1'b1;
        arr_addr     = req.index;
        tag_web      = '1;
        valid_web    = '1;
        dirty_web    = '1;
        data_web     = '1;
        tag_din      = req.tag;
        valid_din    = 1'b0;
        dirty_din    = 1'b0;
        data_din     = '0;
        plru_web     = 1'b1;
        plru_din     = plru_next;

        unique case (state)
            IDLE: begin
                ufp_ready = 1'b1;
                arr_addr  = in_addr.index;
                if ((|ufp_rmask) || (|ufp_wmask)) begin
                    capture = 1'b1;
                    arr_csb = 1'b0;
                    state_d = COMPARE;
                end
            end
            COMPARE: begin
                arr_csb = 1'b0;
                if (any_hit) begin
                    ufp_resp  = 1'b1;
                    ufp_rdata = hit_line[{req.word, 5'b00000} +: 32];
                    if (|req_wmask) begin
                        data_web[hit_way]  = 1'b0;
                        data_din           = merge_line(hit_line, req.word, req_wmask, req_wdata);
                        dirty_web[hit_way] = 1'b0;
                        dirty_din          = 1'b1;
                    end
                    plru_web = 1'b0;
                    state_d  = IDLE;
                end else begin
                    latch_victim = 1'b1;
                    state_d      = miss_dirty ? WRITEBACK : ALLOCATE;
                end
            end
            WRITEBACK: begin
                dfp_write = 1'b1;
                dfp_addr  = {victim_tag, req.index, 5'b00000};
                dfp_wdata = victim_line;
                if (dfp_resp) begin
                    state_d = ALLOCATE;
                end
            end
            ALLOCATE: begin
                dfp_read = 1'b1;
                dfp_addr = {req.tag, req.index, 5'b00000};
                if (dfp_resp) begin
                    arr_csb               = 1'b0;
                    tag_web[victim_way]   = 1'b0;
                    valid_web[victim_way] = 1'b0;
                    dirty_web[victim_way] = 1'b0;
                    data_web[victim_way]  = 1'b0;
                    valid_din             = 1'b1;
                    dirty_din             = 1'b0;
                    data_din              = dfp_rdata;
                    state_d               = LOOKUP;
                end
            end
            LOOKUP: begin
                arr_csb = 1'b0;
                state_d = COMPARE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Request capture and victim snapshot taken when the miss is detected.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req         <= '0;
            req_wmask   <= '0;
            req_wdata   <= '0;
            victim_way  <= '0;
            victim_tag  <= '0;
            victim_line <= '0;
        end else begin
            if (capture) begin
                req       <= in_addr;
                req_wmask <= ufp_wmask;
                req_wdata <= ufp_wdata;
            end
            if (latch_victim) begin
                victim_way  <= miss_way;
                victim_tag  <= way_tag[miss_way];
                victim_line <= way_line[miss_way];
            end
        end
    end

endmodule

// File: tb/tb_cache_ctrl.sv
// Directed bench for cache_ctrl with behavioural arrays and a fixed-pattern memory.
module tb_cache_ctrl;
    import cache_types::*;

    localparam int NS = 16;

    logic                    clk = 1'b0;
    logic                    rst_n = 1'b0;
    logic                    ufp_ready;
    logic [31:0]             ufp_addr = '0;
    logic [3:0]              ufp_rmask = '0;
    logic [3:0]              ufp_wmask = '0;
    logic [31:0]             ufp_wdata = '0;
    logic [31:0]             ufp_rdata;
    logic                    ufp_resp;
    logic [31:0]             dfp_addr;
    logic                    dfp_read;
    logic                    dfp_write;
    logic [LINE_W-1:0]       dfp_wdata;
    logic [LINE_W-1:0]       dfp_rdata = '0;
    logic                    dfp_resp = 1'b0;
    logic                    arr_csb;
    logic [N_SET-1:0]        arr_addr;
    logic [N_WAY-1:0]        tag_web, valid_web, dirty_web, data_web;
    logic [TAG_W-1:0]        tag_din;
    logic                    valid_din, dirty_din;
    logic [LINE_W-1:0]       data_din;
    logic [N_WAY*TAG_W-1:0]  tag_dout;
    logic [N_WAY-1:0]        valid_dout, dirty_dout;
    logic [N_WAY*LINE_W-1:0] data_dout;
    logic                    plru_web;
    logic [2:0]              plru_din;
    logic [2:0]              plru_dout;

    cache_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .ufp_ready(ufp_ready), .ufp_addr(ufp_addr), .ufp_rmask(ufp_rmask),
        .ufp_wmask(ufp_wmask), .ufp_wdata(ufp_wdata), .ufp_rdata(ufp_rdata),
        .ufp_resp(ufp_resp),
        .dfp_addr(dfp_addr), .dfp_read(dfp_read), .dfp_write(dfp_write),
        .dfp_wdata(dfp_wdata), .dfp_rdata(dfp_rdata), .dfp_resp(dfp_resp),
        .arr_csb(arr_csb), .arr_addr(arr_addr),
        .tag_web(tag_web), .valid_web(valid_web), .dirty_web(dirty_web), .data_web(data_web),
        .tag_din(tag_din), .valid_din(valid_din), .dirty_din(dirty_din), .data_din(data_din),
        .tag_dout(tag_dout), .valid_dout(valid_dout), .dirty_dout(dirty_dout),
        .data_dout(data_dout),
        .plru_web(plru_web), .plru_din(plru_din), .plru_dout(plru_dout)
    );

    always #5 clk = ~clk;

    // Behavioural arrays: inputs registered on an edge, write commits one edge later.
    logic [TAG_W-1:0]  tag_mem   [N_WAY][NS];
    logic              valid_mem [N_WAY][NS];
    logic              dirty_mem [N_WAY][NS];
    logic [LINE_W-1:0] data_mem  [N_WAY][NS];
    logic [2:0]        plru_mem  [NS];

    logic              csb_q;
    logic [N_SET-1:0]  addr_q;
    logic [N_WAY-1:0]  tag_web_q, valid_web_q, dirty_web_q, data_web_q;
    logic [TAG_W-1:0]  tag_din_q;
    logic              valid_din_q, dirty_din_q, plru_web_q;
    logic [LINE_W-1:0] data_din_q;
    logic [2:0]        plru_din_q;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            csb_q <= 1'b1; addr_q <= '0; plru_web_q <= 1'b1;
            tag_web_q <= '1; valid_web_q <= '1; dirty_web_q <= '1; data_web_q <= '1;
            tag_din_q <= '0; valid_din_q <= 1'b0; dirty_din_q <= 1'b0;
            data_din_q <= '0; plru_din_q <= '0;
            for (int s = 0; s < NS; s++) begin
                plru_mem[s] <= '0;
                for (int w = 0; w < N_WAY; w++) begin
                    tag_mem[w][s] <= '0; valid_mem[w][s] <= 1'b0;
                    dirty_mem[w][s] <= 1'b0; data_mem[w][s] <= '0;
                end
            end
        end else begin
            if (!csb_q) begin
                for (int w = 0; w < N_WAY; w++) begin
                    if (!tag_web_q[w])   tag_mem[w][addr_q]   <= tag_din_q;
                    if (!valid_web_q[w]) valid_mem[w][addr_q] <= valid_din_q;
                    if (!dirty_web_q[w]) dirty_mem[w][addr_q] <= dirty_din_q;
                    if (!data_web_q[w])  data_mem[w][addr_q]  <= data_din_q;
                end
                if (!plru_web_q) plru_mem[addr_q] <= plru_din_q;
            end
            csb_q <= arr_csb;
            if (!arr_csb) addr_q <= arr_addr;
            tag_web_q <= tag_web; valid_web_q <= valid_web;
            dirty_web_q <= dirty_web; data_web_q <= data_web; plru_web_q <= plru_web;
            tag_din_q <= tag_din; valid_din_q <= valid_din; dirty_din_q <= dirty_din;
            data_din_q <= data_din; plru_din_q <= plru_din;
        end
    end

    always_comb begin
        for (int w = 0; w < N_WAY; w++) begin
            tag_dout[w*TAG_W +: TAG_W]   = tag_mem[w][addr_q];
            valid_dout[w]                = valid_mem[w][addr_q];
            dirty_dout[w]                = dirty_mem[w][addr_q];
            data_dout[w*LINE_W +: LINE_W] = data_mem[w][addr_q];
        end
        plru_dout = plru_mem[addr_q];
    end

    int n_vec = 0;
    int n_err = 0;
    int both_cnt = 0;

    always @(negedge clk) begin
        if (rst_n && dfp_read && dfp_write) both_cnt <= both_cnt + 1;
    end

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] fill_word(input logic [31:0] a, input int i);
        return {a[27:5], 3'(i), 6'h2A};
    endfunction

    function automatic logic [LINE_W-1:0] fill_line(input logic [31:0] a);
        logic [LINE_W-1:0] l;
        for (int i = 0; i < 8; i++) l[32*i +: 32] = fill_word(a, i);
        return l;
    endfunction

    logic [31:0]       r_rdata, r_read_addr, r_write_addr;
    logic [LINE_W-1:0] r_write_data;
    int                r_lat;
    logic              r_saw_read, r_saw_write, r_timeout;

    // One request; services dfp with a 2-cycle latency and waits for ufp_resp.
    task automatic do_req(input logic [31:0] a, input logic [3:0] rm,
                          input logic [3:0] wm, input logic [31:0] wd);
        int  cyc;
        int  dcnt;
        bit  done;
        r_saw_read = 0; r_saw_write = 0; r_timeout = 0; r_lat = 0;
        r_rdata = '0; r_read_addr = '0; r_write_addr = '0; r_write_data = '0;
        @(negedge clk);
        ufp_addr = a; ufp_rmask = rm; ufp_wmask = wm; ufp_wdata = wd;
        @(negedge clk);
        ufp_rmask = '0; ufp_wmask = '0;
        cyc = 1; dcnt = 0; done = 0;
        while (!done) begin
            dfp_resp = 1'b0;
            if (ufp_resp) begin
                r_rdata = ufp_rdata; r_lat = cyc; done = 1;
            end else begin
                if (dfp_write) begin
                    r_saw_write = 1; r_write_addr = dfp_addr; r_write_data = dfp_wdata;
                end
                if (dfp_read) begin
                    r_saw_read = 1; r_read_addr = dfp_addr;
                end
                if (dfp_read || dfp_write) begin
                    dcnt++;
                    if (dcnt == 2) begin
                        dfp_resp  = 1'b1;
                        dfp_rdata = dfp_read ? fill_line(dfp_addr) : '0;
                        dcnt      = 0;
                    end
                end
                if (cyc >= 100) begin
                    r_timeout = 1; done = 1;
                end else begin
                    @(negedge clk);
                    cyc++;
                end
            end
        end
        chk("resp_timeout", 256'(r_timeout), 256'(0));
    endtask

    logic [LINE_W-1:0] exp_line;
    bit                seen;

    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_resp", 256'(ufp_resp), 256'(0));
        chk("rst_dfp_read", 256'(dfp_read), 256'(0));
        chk("rst_dfp_write", 256'(dfp_write), 256'(0));
        chk("rst_dfp_addr", 256'(dfp_addr), 256'(0));
        chk("rst_rdata", 256'(ufp_rdata), 256'(0));
        chk("rst_csb", 256'(arr_csb), 256'(1));
        chk("rst_webs", 256'({tag_web, valid_web, dirty_web, data_web, plru_web}), 256'(17'h1FFFF));
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_ready", 256'(ufp_ready), 256'(1));

        // Cold read miss into set 2
        do_req(32'h0000_0040, 4'hF, 4'h0, '0);
        chk("cold_lat", 256'(r_lat), 256'(5));
        chk("cold_rdata", 256'(r_rdata), 256'(32'h0000_042A));
        chk("cold_rd_addr", 256'(r_read_addr), 256'(32'h40));
        chk("cold_no_wr", 256'(r_saw_write), 256'(0));
        chk("cold_valid", 256'(valid_mem[0][2]), 256'(1));
        chk("cold_dirty", 256'(dirty_mem[0][2]), 256'(0));

        // Repeat read hits in one cycle
        do_req(32'h0000_0040, 4'hF, 4'h0, '0);
        chk("hit_lat", 256'(r_lat), 256'(1));
        chk("hit_rdata", 256'(r_rdata), 256'(32'h0000_042A));
        chk("hit_no_dfp", 256'({r_saw_read, r_saw_write}), 256'(0));
        repeat (2) @(negedge clk);
        chk("hit_plru", 256'(plru_mem[2]), 256'(3'b011));

        // Partial write then back-to-back read
        do_req(32'h0000_0044, 4'h0, 4'h3, 32'hAAAA_BBBB);
        chk("wr_lat", 256'(r_lat), 256'(1));
        do_req(32'h0000_0044, 4'hF, 4'h0, '0);
        chk("raw_rdata", 256'(r_rdata), 256'(32'h0000_BBBB));
        chk("wr_dirty", 256'(dirty_mem[0][2]), 256'(1));

        // Read+write request returns the pre-write word
        do_req(32'h0000_0044, 4'hF, 4'hC, 32'h1234_5678);
        chk("rw_rdata", 256'(r_rdata), 256'(32'h0000_BBBB));
        do_req(32'h0000_0044, 4'hF, 4'h0, '0);
        chk("rw_after", 256'(r_rdata), 256'(32'h1234_BBBB));

        // Fill ways 1..3 of set 2
        do_req(32'h0000_0244, 4'hF, 4'h0, '0);
        chk("fill1_rdata", 256'(r_rdata), 256'(32'h0000_246A));
        chk("fill1_tag", 256'(tag_mem[1][2]), 256'(1));
        do_req(32'h0000_0440, 4'hF, 4'h0, '0);
        chk("fill2_rdata", 256'(r_rdata), 256'(32'h0000_442A));
        do_req(32'h0000_0640, 4'hF, 4'h0, '0);
        chk("fill3_rdata", 256'(r_rdata), 256'(32'h0000_642A));
        repeat (2) @(negedge clk);
        chk("full_plru", 256'(plru_mem[2]), 256'(3'b000));

        // Full set, PLRU victim way 0 is dirty: writeback then allocate
        exp_line = fill_line(32'h40);
        exp_line[63:32] = 32'h1234_BBBB;
        do_req(32'h0000_0840, 4'hF, 4'h0, '0);
        chk("wb_seen", 256'(r_saw_write), 256'(1));
        chk("wb_addr", 256'(r_write_addr), 256'(32'h40));
        chk("wb_data", r_write_data, exp_line);
        chk("wb_rd_addr", 256'(r_read_addr), 256'(32'h840));
        chk("wb_lat", 256'(r_lat), 256'(7));
        chk("wb_rdata", 256'(r_rdata), 256'(32'h0000_842A));
        chk("wb_newtag", 256'(tag_mem[0][2]), 256'(4));

        // Clean victim (way 2): read only
        do_req(32'h0000_0A40, 4'hF, 4'h0, '0);
        chk("clean_no_wr", 256'(r_saw_write), 256'(0));
        chk("clean_rd", 256'({r_saw_read, r_read_addr}), 256'({1'b1, 32'hA40}));
        chk("clean_rdata", 256'(r_rdata), 256'(32'h0000_A42A));
        chk("clean_tag", 256'(tag_mem[2][2]), 256'(5));

        // Make way 1 dirty and steer PLRU to it
        do_req(32'h0000_0240, 4'h0, 4'hF, 32'hDEAD_BEEF);
        do_req(32'h0000_0840, 4'hF, 4'h0, '0);
        do_req(32'h0000_0A40, 4'hF, 4'h0, '0);
        repeat (2) @(negedge clk);
        chk("pre_rst_plru", 256'(plru_mem[2]), 256'(3'b110));

        // Reset while in WRITEBACK
        ufp_addr = 32'h0000_0C40; ufp_rmask = 4'hF;
        @(negedge clk);
        ufp_rmask = '0;
        chk("busy_ready", 256'(ufp_ready), 256'(0));
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            if (dfp_write) seen = 1;
            else @(negedge clk);
        end
        chk("rst_wb_seen", 256'(seen), 256'(1));
        chk("rst_wb_addr", 256'(dfp_addr), 256'(32'h240));
        chk("rst_wb_word0", 256'(dfp_wdata[31:0]), 256'(32'hDEAD_BEEF));
        #2 rst_n = 1'b0;
        #1;
        chk("rst_wr_drop", 256'({dfp_write, dfp_read, ufp_resp}), 256'(0));
        chk("rst_csb_mid", 256'(arr_csb), 256'(1));
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_ready", 256'(ufp_ready), 256'(1));

        // Functional again after reset
        do_req(32'h0000_0040, 4'hF, 4'h0, '0);
        chk("post_rst_lat", 256'(r_lat), 256'(5));
        chk("post_rst_rdata", 256'(r_rdata), 256'(32'h0000_042A));
        chk("post_rst_no_wr", 256'(r_saw_write), 256'(0));

        chk("rd_wr_overlap", 256'(both_cnt), 256'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
